// File: rtl/axi_gpio_pkg.sv
// Shared register offsets, response codes, FSM state types and byte-strobe helpers
// for the parametrised AXI-Lite GPIO.
package axi_gpio_pkg;

   localparam logic [3:0] OFF_DATA  = 4'h0;
   localparam logic [3:0] OFF_DIR   = 4'h4;
   localparam logic [3:0] OFF_IEN   = 4'h8;
   localparam logic [3:0] OFF_STAT  = 4'hC;
   localparam int         CH_STRIDE = 'h10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wrState_e;
   typedef enum logic {R_IDLE, R_DATA} rdState_e;

   function automatic logic [31:0] strobeMask(input logic [3:0] strb);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) begin
         m[8*k +: 8] = {8{strb[k]}};
      end
      return m;
   endfunction

   function automatic logic [31:0] strobeMerge(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
      return (oldVal & ~strobeMask(strb)) | (newVal & strobeMask(strb));
   endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchroniser for asynchronous pad inputs, followed by a one-clock
// edge pulse comparing the synchronised value against its previous sample.
module gpio_in_sync #(
   parameter int WIDTH     = 32,
   parameter int RISE_EDGE = 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] pin_i,
   output logic [WIDTH-1:0] synced_o,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign synced_o = sync_q;
   assign edge_o   = (RISE_EDGE != 0) ? (sync_q & ~prev_q) : (~sync_q & prev_q);

endmodule

// File: rtl/axi_lite_gpio_v2.sv
// AXI-Lite GPIO with CH_COUNT bidirectional channels, per-bit direction, and
// per-bit edge interrupts collapsed onto a single registered irq line.
module axi_lite_gpio_v2
   import axi_gpio_pkg::*;
#(
   parameter int CH_COUNT  = 2,
   parameter int WIDTH     = 32,
   parameter int ADDR_W    = 8,
   parameter int RISE_EDGE = 1
) (
   input  logic                      s_axi_aclk,
   input  logic                      s_axi_areset,
   input  logic [ADDR_W-1:0]         s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [31:0]               s_axi_wdata,
   input  logic [3:0]                s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [ADDR_W-1:0]         s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [31:0]               s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [CH_COUNT*WIDTH-1:0] gpio_i,
   output logic [CH_COUNT*WIDTH-1:0] gpio_o,
   output logic [CH_COUNT*WIDTH-1:0] gpio_oe,
   output logic                      irq
);

   typedef logic [CH_COUNT-1:0][WIDTH-1:0] chanVec_t;

   chanVec_t out_q, out_d, dir_q, dir_d, ien_q, ien_d, stat_q, stat_d;
   chanVec_t pinVec, synced, edges;

   wrState_e    wrState_q, wrState_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   rdState_e    rdState_q, rdState_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q;

   int          wrCh, rdCh;
   logic [3:0]  wrOff, rdOff;
   logic        wrHit, rdHit, wrAccept, rdAccept;
   logic [31:0] wrMask, rdWord;

   assign pinVec = gpio_i;

   for (genvar c = 0; c < CH_COUNT; c++) begin : g_sync
      gpio_in_sync #(
         .WIDTH     (WIDTH),
         .RISE_EDGE (RISE_EDGE)
      ) uSync (
         .clk_i    (s_axi_aclk),
         .reset_i  (s_axi_areset),
         .pin_i    (pinVec[c]),
         .synced_o (synced[c]),
         .edge_o   (edges[c])
      );
   end

   // Only the low two address bits are don't-care; everything above the
   // channel stride selects the channel, so oversized indices decode as unmapped.
   assign wrCh   = int'(s_axi_awaddr) / CH_STRIDE;
   assign rdCh   = int'(s_axi_araddr) / CH_STRIDE;
   assign wrOff  = {s_axi_awaddr[3:2], 2'b00};
   assign rdOff  = {s_axi_araddr[3:2], 2'b00};
   assign wrHit  = wrCh < CH_COUNT;
   assign rdHit  = rdCh < CH_COUNT;
   assign wrMask = strobeMask(s_axi_wstrb);

   assign wrAccept = (wrState_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid && !s_axi_areset;
   assign rdAccept = (rdState_q == R_IDLE) && s_axi_arvalid && !s_axi_areset;

   // Write FSM and register update; edge set is ORed in after the W1C so set wins.
   always_comb begin
      out_d     = out_q;
      dir_d     = dir_q;
      ien_d     = ien_q;
      stat_d    = stat_q | edges;
      wrState_d = wrState_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (wrState_q)
         W_IDLE: begin
            if (wrAccept) begin
               wrState_d = W_RESP;
               bvalid_d  = 1'b1;
               bresp_d   = wrHit ? RESP_OKAY : RESP_SLVERR;
               for (int c = 0; c < CH_COUNT; c++) begin
                  if (wrHit && (wrCh == c)) begin
                     case (wrOff)
                        OFF_DATA: out_d[c] = WIDTH'(strobeMerge(32'(out_q[c]), s_axi_wdata, s_axi_wstrb));
                        OFF_DIR:  dir_d[c] = WIDTH'(strobeMerge(32'(dir_q[c]), s_axi_wdata, s_axi_wstrb));
                        OFF_IEN:  ien_d[c] = WIDTH'(strobeMerge(32'(ien_q[c]), s_axi_wdata, s_axi_wstrb));
                        default:  stat_d[c] = (stat_q[c] & ~WIDTH'(s_axi_wdata & wrMask)) | edges[c];
                     endcase
                  end
               end
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               wrState_d = W_IDLE;
               bvalid_d  = 1'b0;
            end
         end
         default: wrState_d = W_IDLE;
      endcase
   end

   // Read FSM; rdata is captured from current register state, so a same-cycle write is not visible.
   always_comb begin
      rdState_d = rdState_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      rdWord    = '0;
      for (int c = 0; c < CH_COUNT; c++) begin
         if (rdCh == c) begin
            case (rdOff)
               OFF_DATA: rdWord = 32'((dir_q[c] & out_q[c]) | (~dir_q[c] & synced[c]));
               OFF_DIR:  rdWord = 32'(dir_q[c]);
               OFF_IEN:  rdWord = 32'(ien_q[c]);
               default:  rdWord = 32'(stat_q[c]);
            endcase
         end
      end
      case (rdState_q)
         R_IDLE: begin
            if (rdAccept) begin
               rdState_d = R_DATA;
               rvalid_d  = 1'b1;
               rresp_d   = rdHit ? RESP_OKAY : RESP_SLVERR;
               rdata_d   = rdHit ? rdWord : '0;
            end
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rdState_d = R_IDLE;
               rvalid_d  = 1'b0;
            end
         end
         default: rdState_d = R_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         out_q     <= '0;
         dir_q     <= '0;
         ien_q     <= '0;
         stat_q    <= '0;
         wrState_q <= W_IDLE;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
         rdState_q <= R_IDLE;
         rvalid_q  <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         ien_q     <= ien_d;
         stat_q    <= stat_d;
         wrState_q <= wrState_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rdState_q <= rdState_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         irq_q     <= |(stat_q & ien_q);
      end
   end

   assign s_axi_awready = wrAccept;
   assign s_axi_wready  = wrAccept;
   assign s_axi_arready = rdAccept;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign gpio_o        = out_q;
   assign gpio_oe       = dir_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_axi_lite_gpio_v2.sv
// Scoreboard bench for axi_lite_gpio_v2: directed scenarios plus random register
// traffic and pin activity, checked against a register-map model.
module tb_axi_lite_gpio_v2;

   localparam int CH = 2;
   localparam int W  = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [CH*W-1:0] gpioIn, gpioOut, gpioOe;
   logic          irq;

   always #5 clk = ~clk;

   axi_lite_gpio_v2 #(.CH_COUNT(CH), .WIDTH(W), .ADDR_W(AW), .RISE_EDGE(1)) dut (
      .s_axi_aclk    (clk),
      .s_axi_areset  (reset),
      .s_axi_awaddr  (awaddr),
      .s_axi_awvalid (awvalid),
      .s_axi_awready (awready),
      .s_axi_wdata   (wdata),
      .s_axi_wstrb   (wstrb),
      .s_axi_wvalid  (wvalid),
      .s_axi_wready  (wready),
      .s_axi_bresp   (bresp),
      .s_axi_bvalid  (bvalid),
      .s_axi_bready  (bready),
      .s_axi_araddr  (araddr),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata   (rdata),
      .s_axi_rresp   (rresp),
      .s_axi_rvalid  (rvalid),
      .s_axi_rready  (rready),
      .gpio_i        (gpioIn),
      .gpio_o        (gpioOut),
      .gpio_oe       (gpioOe),
      .irq           (irq)
   );

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
   } rdExp_t;

   int          testsRun = 0;
   int          testsFailed = 0;
   int          bDone = 0;
   int          rDone = 0;
   logic [1:0]  bQ[$];
   rdExp_t      rQ[$];
   rdExp_t      monExp;
   logic [31:0] mOut[CH], mDir[CH], mIen[CH], mStat[CH], mPin[CH];

   function automatic void checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void failTimeout(string name);
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endfunction

   function automatic void resetModel();
      for (int c = 0; c < CH; c++) begin
         mOut[c] = '0; mDir[c] = '0; mIen[c] = '0; mStat[c] = '0;
      end
      bQ.delete();
      rQ.delete();
   endfunction

   function automatic logic [31:0] laneUpdate(logic [31:0] oldVal, logic [31:0] newVal, logic [3:0] strb);
      logic [31:0] r = oldVal;
      for (int k = 0; k < 4; k++)
         if (strb[k]) r[8*k +: 8] = newVal[8*k +: 8];
      return r;
   endfunction

   function automatic logic [1:0] modelWrite(logic [7:0] addr, logic [31:0] data, logic [3:0] strb);
      int ch = int'(addr) / 16;
      int idx = (int'(addr) / 4) % 4;
      if (ch >= CH) return 2'b10;
      case (idx)
         0: mOut[ch] = laneUpdate(mOut[ch], data, strb);
         1: mDir[ch] = laneUpdate(mDir[ch], data, strb);
         2: mIen[ch] = laneUpdate(mIen[ch], data, strb);
         default: for (int k = 0; k < 4; k++)
                     if (strb[k]) mStat[ch][8*k +: 8] = mStat[ch][8*k +: 8] & ~data[8*k +: 8];
      endcase
      return 2'b00;
   endfunction

   function automatic rdExp_t modelRead(logic [7:0] addr);
      rdExp_t e;
      int ch = int'(addr) / 16;
      int idx = (int'(addr) / 4) % 4;
      if (ch >= CH) begin
         e.resp = 2'b10; e.data = '0;
         return e;
      end
      e.resp = 2'b00;
      case (idx)
         0: e.data = (mDir[ch] & mOut[ch]) | (~mDir[ch] & mPin[ch]);
         1: e.data = mDir[ch];
         2: e.data = mIen[ch];
         default: e.data = mStat[ch];
      endcase
      return e;
   endfunction

   function automatic logic modelIrq();
      logic any = 1'b0;
      for (int c = 0; c < CH; c++) if ((mStat[c] & mIen[c]) != 0) any = 1'b1;
      return any;
   endfunction

   // Monitor: pops the scoreboard whenever a response handshake completes.
   always @(negedge clk) begin
      if (!reset) begin
         if (bvalid && bready) begin
            if (bQ.size() == 0) failTimeout("unexpected bresp");
            else checkOutput("bresp", 64'(bresp), 64'(bQ.pop_front()));
            bDone++;
         end
         if (rvalid && rready) begin
            if (rQ.size() == 0) failTimeout("unexpected rdata");
            else begin
               monExp = rQ.pop_front();
               checkOutput("rresp", 64'(rresp), 64'(monExp.resp));
               checkOutput("rdata", 64'(rdata), 64'(monExp.data));
            end
            rDone++;
         end
      end
   end

   task automatic waitB(input int target);
      for (int i = 0; i < 50 && bDone < target; i++) @(posedge clk);
      if (bDone < target) failTimeout("write response");
   endtask

   task automatic waitR(input int target);
      for (int i = 0; i < 50 && rDone < target; i++) @(posedge clk);
      if (rDone < target) failTimeout("read response");
   endtask

   task automatic applyWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int target;
      bit acc = 0;
      @(posedge clk); #1;
      target = bDone + 1;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (awready && wready) begin
            acc = 1;
            bQ.push_back(modelWrite(addr, data, strb));
         end
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      if (!acc) failTimeout("write accept");
      else waitB(target);
   endtask

   task automatic applyRead(input logic [7:0] addr);
      int target;
      bit acc = 0;
      @(posedge clk); #1;
      target = rDone + 1;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (arready) begin
            acc = 1;
            rQ.push_back(modelRead(addr));
         end
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      if (!acc) failTimeout("read accept");
      else waitR(target);
   endtask

   // Drive new pad values and let them settle through the synchroniser.
   task automatic applyStimulus(input logic [31:0] p0, input logic [31:0] p1);
      @(posedge clk); #1;
      mStat[0] = mStat[0] | (p0 & ~mPin[0]);
      mStat[1] = mStat[1] | (p1 & ~mPin[1]);
      mPin[0] = p0; mPin[1] = p1;
      gpioIn = {mPin[1], mPin[0]};
      repeat (6) @(posedge clk);
   endtask

   task automatic checkPins(input string tag);
      @(negedge clk);
      checkOutput({tag, " gpio_o"}, 64'(gpioOut), {mOut[1], mOut[0]});
      checkOutput({tag, " gpio_oe"}, 64'(gpioOe), {mDir[1], mDir[0]});
      checkOutput({tag, " irq"}, 64'(irq), 64'(modelIrq()));
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0;
      rdExp_t held;
      logic [7:0] rAddr;
      reset = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      mPin[0] = '0; mPin[1] = '0;
      gpioIn = '0;
      resetModel();

      // Reset: handshakes held off even with requests presented
      repeat (2) @(posedge clk); #1;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      checkOutput("reset awready", 64'(awready), 0);
      checkOutput("reset wready", 64'(wready), 0);
      checkOutput("reset arready", 64'(arready), 0);
      checkOutput("reset bvalid", 64'(bvalid), 0);
      checkOutput("reset rvalid", 64'(rvalid), 0);
      checkOutput("reset rdata", 64'(rdata), 0);
      checkOutput("reset gpio_o", 64'(gpioOut), 0);
      checkOutput("reset gpio_oe", 64'(gpioOe), 0);
      checkOutput("reset irq", 64'(irq), 0);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      reset = 1'b0;

      // Direction mix on channel 0
      applyWrite(8'h04, 32'h0000FFFF, 4'hF);
      applyWrite(8'h00, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      checkOutput("gpio_oe ch0", 64'(gpioOe[31:0]), 64'h0000FFFF);
      checkOutput("gpio_o ch0", 64'(gpioOut[31:0]), 64'hDEADBEEF);
      applyStimulus(32'h12340000, 32'h0);
      applyRead(8'h00);

      // Unmapped channel
      applyWrite(8'h20, 32'hBABACECE, 4'hF);
      applyRead(8'h24);
      checkPins("unmapped");

      // Partial strobe on channel 1
      applyWrite(8'h10, 32'hFFFFFFFF, 4'h3);
      @(negedge clk);
      checkOutput("gpio_o ch1 strobed", 64'(gpioOut[63:32]), 64'h0000FFFF);

      // Edge interrupt timing on gpio[32]
      applyWrite(8'h18, 32'h1, 4'hF);
      @(posedge clk); #1;
      mPin[1] = 32'h1; mStat[1] = mStat[1] | 32'h1;
      gpioIn = {mPin[1], mPin[0]};
      @(posedge clk); @(posedge clk);
      @(posedge clk); @(negedge clk);
      checkOutput("irq on stat edge", 64'(irq), 0);
      @(posedge clk); @(negedge clk);
      checkOutput("irq one clock after stat", 64'(irq), 1);
      applyRead(8'h1C);
      applyWrite(8'h1C, 32'h1, 4'hF);
      @(negedge clk);
      checkOutput("irq after W1C", 64'(irq), 0);

      // Edge landing on the W1C cycle: set wins
      applyStimulus(mPin[0], 32'h0);
      @(posedge clk); #1;
      mPin[1] = 32'h1; mStat[1] = mStat[1] | 32'h1;
      gpioIn = {mPin[1], mPin[0]};
      awaddr = 8'h1C; wdata = 32'h1; wstrb = 4'hF; bready = 1;
      @(posedge clk);
      @(posedge clk); #1;
      t0 = bDone;
      awvalid = 1; wvalid = 1;
      @(negedge clk);
      checkOutput("awready on clear cycle", 64'(awready), 1);
      bQ.push_back(2'b00);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      waitB(t0 + 1);
      applyRead(8'h1C);
      checkPins("set wins");

      // Back-pressure on B with a second write waiting
      @(posedge clk); #1;
      t0 = bDone;
      awaddr = 8'h08; wdata = 32'h000000A5; wstrb = 4'hF;
      awvalid = 1; wvalid = 1; bready = 0;
      @(negedge clk);
      checkOutput("stall write1 accept", 64'(awready), 1);
      bQ.push_back(modelWrite(8'h08, 32'h000000A5, 4'hF));
      @(posedge clk); #1;
      awaddr = 8'h14; wdata = 32'h0F0F0F0F;
      repeat (3) begin
         @(negedge clk);
         checkOutput("bvalid held", 64'(bvalid), 1);
         checkOutput("write2 blocked", 64'(awready), 0);
      end
      @(posedge clk); #1;
      bready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("write2 accepted after handshake", 64'(awready), 1);
      bQ.push_back(modelWrite(8'h14, 32'h0F0F0F0F, 4'hF));
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0;
      waitB(t0 + 2);
      checkPins("after stall");

      // R stall, duplicate arvalid, then reset mid-response
      @(posedge clk); #1;
      held = modelRead(8'h04);
      araddr = 8'h04; arvalid = 1; rready = 0;
      @(negedge clk);
      checkOutput("stall arready", 64'(arready), 1);
      @(posedge clk); #1;
      arvalid = 0;
      @(negedge clk);
      checkOutput("stall rvalid", 64'(rvalid), 1);
      checkOutput("stall rdata", 64'(rdata), 64'(held.data));
      @(posedge clk); #1;
      araddr = 8'h10; arvalid = 1;
      @(negedge clk);
      checkOutput("second arvalid ignored", 64'(arready), 0);
      @(posedge clk); #1;
      arvalid = 0;
      @(negedge clk);
      checkOutput("rdata stable", 64'(rdata), 64'(held.data));
      @(posedge clk); #1;
      reset = 1;
      mPin[0] = '0; mPin[1] = '0;
      gpioIn = '0;
      @(posedge clk); @(negedge clk);
      checkOutput("rvalid dropped by reset", 64'(rvalid), 0);
      resetModel();
      @(posedge clk); #1;
      reset = 0;
      checkPins("post reset");

      // Random traffic
      for (int it = 0; it < 60; it++) begin
         int op = $urandom_range(0, 9);
         rAddr = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
         if (op < 4) applyWrite(rAddr, $urandom, 4'($urandom_range(0, 15)));
         else if (op < 8) applyRead(rAddr);
         else applyStimulus($urandom, $urandom);
         checkPins("random");
      end

      repeat (4) @(posedge clk);
      checkOutput("bQ drained", 64'(bQ.size()), 0);
      checkOutput("rQ drained", 64'(rQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
